// File: rtl/count_sequencer.sv
// count_sequencer: command sequencer for an external up/down counter.
// Accepts start/stop pulses, divides the clock into count ticks, and issues
// registered clear/load/step pulses. In one-shot mode it halts in DONE once
// the fed-back count reaches the target. Every output is a register, so each
// response appears one cycle after the causing input is sampled.
module count_sequencer #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 8388608
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir_up,
    input  logic             one_shot,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_clr,
    output logic             cnt_load,
    output logic [WIDTH-1:0] load_val,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    // Prescaler width covers 0 .. TICK_DIV-1.
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t           r_state;
    logic [PW-1:0]    r_presc;
    logic             r_dir;
    logic             r_one_shot;
    logic [WIDTH-1:0] r_limit;
    logic             r_cnt_en;
    logic             r_cnt_clr;
    logic             r_cnt_load;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_next;
    logic [PW-1:0]    w_presc_next;
    logic             w_dir_next;
    logic             w_one_shot_next;
    logic [WIDTH-1:0] w_limit_next;
    logic             w_cnt_en_next;
    logic             w_cnt_clr_next;
    logic             w_cnt_load_next;
    logic             w_tick;
    logic [WIDTH-1:0] w_target;

    // A tick happens on the last prescaler value; only meaningful in RUN.
    assign w_tick   = (r_presc == TICK_LAST);
    // One-shot end point: the loaded limit when counting up, zero when down.
    assign w_target = r_dir ? r_limit : '0;

    // Next-state and next-output decode; stop always outranks start.
    always_comb begin
        w_state_next    = r_state;
        w_presc_next    = r_presc;
        w_dir_next      = r_dir;
        w_one_shot_next = r_one_shot;
        w_limit_next    = r_limit;
        w_cnt_en_next   = 1'b0;
        w_cnt_clr_next  = 1'b0;
        w_cnt_load_next = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (stop) begin
                    // Stop returns DONE to IDLE; in IDLE it has no effect.
                    w_state_next = S_IDLE;
                end else if (start) begin
                    // Fresh launch: latch settings, restart the prescaler,
                    // and initialise the counter (clear for up, load for down).
                    w_state_next    = S_RUN;
                    w_presc_next    = '0;
                    w_dir_next      = dir_up;
                    w_one_shot_next = one_shot;
                    w_limit_next    = limit;
                    w_cnt_clr_next  = dir_up;
                    w_cnt_load_next = ~dir_up;
                end
            end
            S_RUN: begin
                if (stop) begin
                    // Pause freezes the prescaler at its current value.
                    w_state_next = S_PAUSE;
                end else if (w_tick) begin
                    w_presc_next = '0;
                    if (r_one_shot && (count == w_target)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_cnt_en_next = 1'b1;
                    end
                end else begin
                    w_presc_next = r_presc + PW'(1);
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    w_state_next = S_IDLE;
                end else if (start) begin
                    // Resume with the frozen prescaler and latched settings.
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, prescaler, latched settings and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_dir      <= 1'b0;
            r_one_shot <= 1'b0;
            r_limit    <= '0;
            r_cnt_en   <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_cnt_load <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_presc    <= w_presc_next;
            r_dir      <= w_dir_next;
            r_one_shot <= w_one_shot_next;
            r_limit    <= w_limit_next;
            r_cnt_en   <= w_cnt_en_next;
            r_cnt_clr  <= w_cnt_clr_next;
            r_cnt_load <= w_cnt_load_next;
            r_busy     <= (w_state_next == S_RUN);
            r_done     <= (w_state_next == S_DONE);
        end
    end

    assign cnt_en   = r_cnt_en;
    assign cnt_up   = r_dir;
    assign cnt_clr  = r_cnt_clr;
    assign cnt_load = r_cnt_load;
    assign load_val = r_limit;
    assign busy     = r_busy;
    assign done     = r_done;
    assign state    = r_state;

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter datapath width.
REQ-002 SHALL have parameter TICK_DIV, default 8388608, giving CLOCK cycles per count tick; legal range is 2 or more.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle command pulse, already synchronized.
REQ-006 SHALL have port stop  input  1  single-cycle command pulse, already synchronized.
REQ-007 SHALL have port dir_up  input  1  requested direction (1 = up, 0 = down), sampled only on an accepted start.
REQ-008 SHALL have port one_shot  input  1  requested mode (1 = stop at target, 0 = free-run), sampled only on an accepted start.
REQ-009 SHALL have port limit  input  WIDTH  up-mode target and down-mode load value, sampled only on an accepted start.
REQ-010 SHALL have port count  input  WIDTH  current value fed back from the counter datapath.
REQ-011 SHALL have port cnt_en  output  1  one-cycle step pulse to the counter.
REQ-012 SHALL have port cnt_up  output  1  latched direction to the counter.
REQ-013 SHALL have port cnt_clr  output  1  one-cycle clear-to-0 pulse.
REQ-014 SHALL have port cnt_load  output  1  one-cycle load pulse.
REQ-015 SHALL have port load_val  output  WIDTH  latched limit.
REQ-016 SHALL have port busy  output  1  high in RUN.
REQ-017 SHALL have port done  output  1  high in DONE.
REQ-018 SHALL have port state  output  2  encoding IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-019 SHALL register all outputs; every response appears the cycle after the causing input is sampled.
REQ-020 SHALL accept start only in IDLE, PAUSE or DONE; start in RUN SHALL be ignored.
REQ-021 SHALL give stop priority when start and stop are high in the same cycle.
REQ-022 SHALL, on start in IDLE or DONE:
  - latch dir_up, one_shot and limit;
  - reset the prescaler to 0;
  - enter RUN;
  - pulse cnt_clr if dir_up=1, else pulse cnt_load with load_val=limit.
REQ-023 SHALL, in RUN, increment the prescaler each cycle and generate a tick when it equals TICK_DIV-1; the prescaler SHALL then wrap to 0.
REQ-024 SHALL pulse cnt_en for exactly one cycle per tick in RUN, so the first cnt_en occurs TICK_DIV cycles after the clr/load pulse.
REQ-025 SHALL define target as the latched limit when up and as 0 when down.
REQ-026 SHALL, in one-shot mode, suppress cnt_en and enter DONE on a tick where count equals target.
REQ-027 SHALL, in free-run mode, never enter DONE; the counter datapath wraps on its own (up: all-ones to 0; down: 0 to all-ones).
REQ-028 SHALL move RUN to PAUSE on stop, freezing the prescaler, and SHALL issue no cnt_en in PAUSE.
REQ-029 SHALL move PAUSE to RUN on start, resuming from the frozen prescaler value with no clr/load pulse and the latched settings unchanged.
REQ-030 SHALL move PAUSE or DONE to IDLE on stop; stop in IDLE SHALL be ignored.
REQ-031 SHALL hold done high for as long as the state is DONE.
REQ-032 SHALL never assert cnt_en, cnt_clr and cnt_load together; at most one of them is high in any cycle.

Reset
REQ-033 SHALL, on rst high at a clock edge, force IDLE, clear the prescaler to 0, and drive cnt_en=cnt_clr=cnt_load=busy=done=0, cnt_up=0, load_val=0, state=00, regardless of current state or pending commands.
REQ-034 SHALL let rst take priority over start and stop in the same cycle.

Verification (TICK_DIV=4, WIDTH=4)
REQ-035 SHALL cover: start with dir_up=1, one_shot=0 -> cnt_clr one cycle later; cnt_en every 4th cycle thereafter; the model counter wraps from 15 to 0 with no DONE.
REQ-036 SHALL cover: start with dir_up=1, one_shot=1, limit=3 -> exactly 3 cnt_en pulses, then DONE with done=1, count=3, and no further cnt_en.
REQ-037 SHALL cover: start with dir_up=0, one_shot=1, limit=2 -> cnt_load with load_val=2, then 2 cnt_en pulses with cnt_up=0, then DONE with count=0.
REQ-038 SHALL cover: stop mid-RUN with the prescaler at 2, then start after 10 cycles -> PAUSE with no cnt_en; after resume, the next cnt_en arrives 2 cycles later.
REQ-039 SHALL cover: start and stop in the same cycle while in PAUSE -> IDLE.
REQ-040 SHALL cover: rst in RUN with the prescaler at 3 -> the next cycle has all outputs 0 and no cnt_en.
